// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and constants for the keypad scanner
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int KEY_W    = 5;

    // Lowest-index low row wins when several keys share the active column.
    function automatic logic [1:0] lowest_low(input logic [NUM_ROWS-1:0] rows);
        lowest_low = 2'd0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (!rows[i]) lowest_low = 2'(i);
        end
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// rtl/keypad_tick_gen.sv - one-cycle scan tick every CLK_DIV clocks
module keypad_tick_gen #(
    parameter int CLK_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == CW'(CLK_DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CW'(CLK_DIV - 1));

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scan with press/release debounce
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int CLK_DIV        = 1000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       row_in,
    output logic [3:0]       col_out,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    output logic             key_down
);

    localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);

    logic             tick;
    logic [3:0]       row_m, row_s;
    state_t           state, state_n;
    logic [1:0]       col_idx, col_n;
    logic [1:0]       cap_row, cap_row_n;
    logic [3:0]       cap_pat, cap_pat_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic             done;
    logic [KEY_W-1:0] key_n;
    logic             valid_n, down_n;

    keypad_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign cnt_inc = cnt + 1'b1;
    assign done    = (cnt_inc == CNT_W'(DEBOUNCE_TICKS));
    assign col_out = ~(4'(1) << col_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_m     <= 4'hF;
            row_s     <= 4'hF;
            state     <= SCAN;
            col_idx   <= 2'd0;
            cap_row   <= 2'd0;
            cap_pat   <= 4'hF;
            cnt       <= '0;
            key       <= '0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            row_m     <= row_in;
            row_s     <= row_m;
            state     <= state_n;
            col_idx   <= col_n;
            cap_row   <= cap_row_n;
            cap_pat   <= cap_pat_n;
            cnt       <= cnt_n;
            key       <= key_n;
            key_valid <= valid_n;
            key_down  <= down_n;
        end
    end

    always_comb begin
        state_n   = state;
        col_n     = col_idx;
        cap_row_n = cap_row;
        cap_pat_n = cap_pat;
        cnt_n     = cnt;
        key_n     = key;
        valid_n   = 1'b0;
        down_n    = key_down;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (row_s == 4'hF) begin
                        col_n = col_idx + 1'b1;
                    end else begin
                        cap_row_n = lowest_low(row_s);
                        cap_pat_n = row_s;
                        cnt_n     = '0;
                        state_n   = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (row_s == cap_pat) begin
                        cnt_n = cnt_inc;
                        if (done) begin
                            key_n   = {1'b0, cap_row, col_idx};
                            valid_n = 1'b1;
                            down_n  = 1'b1;
                            state_n = HELD;
                        end
                    end else begin
                        col_n   = col_idx + 1'b1;
                        state_n = SCAN;
                    end
                end
                // Only the captured row is watched; other keys are ignored.
                HELD: begin
                    if (row_s[cap_row]) begin
                        cnt_n   = '0;
                        state_n = RELEASE;
                    end
                end
                RELEASE: begin
                    if (row_s[cap_row]) begin
                        cnt_n = cnt_inc;
                        if (done) begin
                            down_n  = 1'b0;
                            col_n   = col_idx + 1'b1;
                            state_n = SCAN;
                        end
                    end else begin
                        state_n = HELD;
                    end
                end
                default: state_n = SCAN;
            endcase
        end
    end

endmodule
